// File: rtl/sfq_split_monitor.sv
// Pulse monitor for the RSFQ splitter model: turns toggle-encoded q0/q1 streams
// into pulse events, pairs them within a skew window and keeps saturating counts.
module sfq_split_monitor #(
  parameter int CNT_W    = 16,
  parameter int SKEW_MAX = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a0,
  input  logic             a1,
  input  logic             clr_cnt,
  output logic             pair_ok,
  output logic             skew_err,
  output logic             dup_err,
  output logic             x_seen,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] pair_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT1 = 2'd1,
    WAIT0 = 2'd2
  } state_t;

  localparam logic [3:0]       SKEW_T  = 4'(SKEW_MAX);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t     state;
  logic [3:0] tmr;
  logic       s0, p0, s1, p1;
  logic       ev0, ev1;
  logic       pok_n, skew_n, dup_n;
  logic       x_now;

  assign ev0       = s0 ^ p0;
  assign ev1       = s1 ^ p1;
  assign state_dbg = state;
  // Only meaningful in a 4-state simulator; reduces to constant 0 in hardware.
  assign x_now     = ((a0 !== 1'b0) && (a0 !== 1'b1)) || ((a1 !== 1'b0) && (a1 !== 1'b1));

  // Loading both taps with the live level on reset keeps reset release event-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      s0 <= a0;
      p0 <= a0;
      s1 <= a1;
      p1 <= a1;
    end else begin
      s0 <= a0;
      p0 <= s0;
      s1 <= a1;
      p1 <= s1;
    end
  end

  always_comb begin
    pok_n  = 1'b0;
    skew_n = 1'b0;
    dup_n  = 1'b0;
    case (state)
      IDLE:  pok_n = ev0 && ev1;
      WAIT1: begin
        if (ev1)                pok_n  = 1'b1;
        else if (ev0)           dup_n  = 1'b1;
        else if (tmr == SKEW_T) skew_n = 1'b1;
      end
      WAIT0: begin
        if (ev0)                pok_n  = 1'b1;
        else if (ev1)           dup_n  = 1'b1;
        else if (tmr == SKEW_T) skew_n = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tmr      <= 4'd0;
      pair_ok  <= 1'b0;
      skew_err <= 1'b0;
      dup_err  <= 1'b0;
    end else begin
      pair_ok  <= pok_n;
      skew_err <= skew_n;
      dup_err  <= dup_n;
      case (state)
        IDLE: begin
          if (ev0 && !ev1) begin
            state <= WAIT1;
            tmr   <= 4'd1;
          end else if (ev1 && !ev0) begin
            state <= WAIT0;
            tmr   <= 4'd1;
          end
        end
        WAIT1: begin
          // A same-branch pulse alongside the partner opens the next wait.
          if (ev1) begin
            if (ev0) begin
              tmr <= 4'd1;
            end else begin
              state <= IDLE;
              tmr   <= 4'd0;
            end
          end else if (ev0) begin
            tmr <= 4'd1;
          end else if (tmr == SKEW_T) begin
            state <= IDLE;
            tmr   <= 4'd0;
          end else begin
            tmr <= tmr + 4'd1;
          end
        end
        WAIT0: begin
          if (ev0) begin
            if (ev1) begin
              tmr <= 4'd1;
            end else begin
              state <= IDLE;
              tmr   <= 4'd0;
            end
          end else if (ev1) begin
            tmr <= 4'd1;
          end else if (tmr == SKEW_T) begin
            state <= IDLE;
            tmr   <= 4'd0;
          end else begin
            tmr <= tmr + 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          tmr   <= 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      cnt0     <= '0;
      cnt1     <= '0;
      pair_cnt <= '0;
      err_cnt  <= '0;
      x_seen   <= 1'b0;
    end else begin
      if (ev0 && cnt0 != CNT_MAX)                    cnt0     <= cnt0 + 1'b1;
      if (ev1 && cnt1 != CNT_MAX)                    cnt1     <= cnt1 + 1'b1;
      if (pok_n && pair_cnt != CNT_MAX)              pair_cnt <= pair_cnt + 1'b1;
      if ((skew_n || dup_n) && err_cnt != CNT_MAX)   err_cnt  <= err_cnt + 1'b1;
      if (x_now)                                     x_seen   <= 1'b1;
    end
  end

endmodule
